// File: rtl/regfile_sb.sv
// regfile_sb: register file with a pending-write scoreboard.
//
// Holds NREGS registers of XLEN bits plus one pending bit per register.
// An accepted issue marks its destination pending; a write-back stores
// the data and clears the pending bit. Reads bypass same-cycle write data.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rs1, rs2            read addresses
//   rd1, rd2            read data (combinational, with write bypass)
//   rs1_busy, rs2_busy  pending flag of the addressed register (combinational)
//   we, rd, wd          write-back enable, address, data
//   iss_valid, iss_rd   issue request and its destination register
//   iss_ready           issue can be accepted this cycle
//   pend_cnt            registered count of pending registers
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  output logic [CW-1:0]   pend_cnt
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pend;
  logic [CW-1:0]    cnt_q;

  logic             wr_en;
  logic             iss_acc;
  logic             set_en;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] pend_nxt;
  logic             cnt_inc;
  logic             cnt_dec;

  // True for the hardwired zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZR && (a == '0);
  endfunction

  // A write-back for the zero register is dropped entirely.
  assign wr_en = we && !is_zero(rd);

  // Read ports: zero register first, then same-cycle bypass, then array.
  assign rd1 = is_zero(rs1) ? '0 : ((we && (rs1 == rd)) ? wd : rf[rs1]);
  assign rd2 = is_zero(rs2) ? '0 : ((we && (rs2 == rd)) ? wd : rf[rs2]);

  // A register being written back this cycle is no longer busy to a reader.
  assign rs1_busy = !is_zero(rs1) && pend[rs1] && !(we && (rd == rs1));
  assign rs2_busy = !is_zero(rs2) && pend[rs2] && !(we && (rd == rs2));

  // Issue may proceed if the destination is free or is retiring right now.
  assign iss_ready = is_zero(iss_rd) || !pend[iss_rd] || (we && (rd == iss_rd));
  assign iss_acc   = iss_valid && iss_ready;
  assign set_en    = iss_acc && !is_zero(iss_rd);

  // Next pending vector; set is applied after clear so a same-register
  // retire and re-issue leaves the bit owned by the new instruction.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[iss_rd] = 1'b1;
    if (wr_en)  clr_mask[rd]     = 1'b1;
    pend_nxt = (pend & ~clr_mask) | set_mask;
  end

  // Counter deltas track the actual change of the pending vector.
  // A set only adds when the bit was clear; a clear only subtracts when
  // the bit was set and is not being re-set on the same edge.
  always_comb begin
    cnt_inc = set_en && !pend[iss_rd];
    cnt_dec = wr_en && pend[rd] && !(set_en && (iss_rd == rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd] <= wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pend_cnt = cnt_q;

endmodule
